// File: rtl/ifu_pkg.sv
// Shared IFU types and line-geometry constants.
package ifu_pkg;

  typedef enum logic [1:0] {
    S_ISSUE,
    S_CAPTURE,
    S_SERVE
  } t_fetch_state;

  localparam int unsigned LINE_BYTES       = 16;
  localparam int unsigned WORDS_PER_LINE   = 4;
  localparam int unsigned LINE_OFFSET_BITS = 4;
  localparam int unsigned WORD_SEL_MSB     = 3;
  localparam int unsigned WORD_SEL_LSB     = 2;

endpackage

// File: rtl/ifu_word_select.sv
// Combinational selection of one instruction word out of a fetched line.
module ifu_word_select
  import ifu_pkg::*;
#(
  parameter int unsigned LINE_WIDTH = 128,
  parameter int unsigned INST_WIDTH = 32
) (
  input  logic [LINE_WIDTH-1:0]                line_data,
  input  logic [WORD_SEL_MSB-WORD_SEL_LSB:0]   word_sel,
  output logic [INST_WIDTH-1:0]                word
);

  logic [WORDS_PER_LINE-1:0][INST_WIDTH-1:0] words;

  always_comb begin
    words = line_data;
    word  = words[word_sel];
  end

endmodule

// File: rtl/ifu_fetch_ctrl.sv
// Fetch controller: owns the PC, fetches 128-bit lines and serves words to decode.
module ifu_fetch_ctrl
  import ifu_pkg::*;
#(
  parameter int unsigned            ADRS_WIDTH = 32,
  parameter int unsigned            LINE_WIDTH = 128,
  parameter int unsigned            INST_WIDTH = 32,
  parameter logic [ADRS_WIDTH-1:0]  RESET_PC   = '0
) (
  input  logic                  clock,
  input  logic                  rst_n,
  output logic [ADRS_WIDTH-1:0] imem_address,
  input  logic [LINE_WIDTH-1:0] imem_q,
  input  logic                  redirect_valid,
  input  logic [ADRS_WIDTH-1:0] redirect_pc,
  output logic                  inst_valid,
  input  logic                  inst_ready,
  output logic [INST_WIDTH-1:0] inst,
  output logic [ADRS_WIDTH-1:0] inst_pc
);

  localparam int unsigned LINE_IDX_W = ADRS_WIDTH - LINE_OFFSET_BITS;
  localparam int unsigned SEL_W      = WORD_SEL_MSB - WORD_SEL_LSB + 1;
  localparam logic [ADRS_WIDTH-1:0] WORD_MASK =
    {{(ADRS_WIDTH-WORD_SEL_LSB){1'b1}}, {WORD_SEL_LSB{1'b0}}};

  t_fetch_state            state_q, state_d;
  logic [ADRS_WIDTH-1:0]   pc_q, pc_d;
  logic [LINE_IDX_W-1:0]   req_line_q, req_line_d;
  logic [LINE_WIDTH-1:0]   line_data_q, line_data_d;
  logic [SEL_W-1:0]        word_sel;
  logic                    fire;

  assign word_sel = pc_q[WORD_SEL_MSB:WORD_SEL_LSB];
  assign inst_pc  = pc_q;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    req_line_d   = req_line_q;
    line_data_d  = line_data_q;
    inst_valid   = 1'b0;
    fire         = 1'b0;
    imem_address = {{LINE_OFFSET_BITS{1'b0}}, req_line_q};

    unique case (state_q)
      S_ISSUE: begin
        imem_address = {{LINE_OFFSET_BITS{1'b0}}, pc_q[ADRS_WIDTH-1:LINE_OFFSET_BITS]};
        req_line_d   = pc_q[ADRS_WIDTH-1:LINE_OFFSET_BITS];
        state_d      = S_CAPTURE;
      end
      S_CAPTURE: begin
        line_data_d = imem_q;
        state_d     = S_SERVE;
      end
      S_SERVE: begin
        inst_valid = !redirect_valid;
        fire       = !redirect_valid && inst_ready;
        if (fire) begin
          pc_d = pc_q + ADRS_WIDTH'(4);
          if (word_sel == '1) begin
            state_d = S_ISSUE;
          end
        end
      end
      default: state_d = S_ISSUE;
    endcase

    // Redirect overrides everything, including a capture already in flight.
    if (redirect_valid) begin
      pc_d        = redirect_pc & WORD_MASK;
      req_line_d  = req_line_q;
      line_data_d = line_data_q;
      state_d     = S_ISSUE;
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_ISSUE;
      pc_q        <= RESET_PC;
      req_line_q  <= RESET_PC[ADRS_WIDTH-1:LINE_OFFSET_BITS];
      line_data_q <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      req_line_q  <= req_line_d;
      line_data_q <= line_data_d;
    end
  end

  ifu_word_select #(
    .LINE_WIDTH (LINE_WIDTH),
    .INST_WIDTH (INST_WIDTH)
  ) u_word_select (
    .line_data (line_data_q),
    .word_sel  (word_sel),
    .word      (inst)
  );

endmodule

// File: tb/tb_ifu_fetch_ctrl.sv
// Bench for ifu_fetch_ctrl: directed vector table, async-reset sequence, random run vs model.
module tb_ifu_fetch_ctrl;

  logic         clock;
  logic         rst_n;
  logic [31:0]  imem_address;
  logic [127:0] imem_q;
  logic         redirect_valid;
  logic [31:0]  redirect_pc;
  logic         inst_valid;
  logic         inst_ready;
  logic [31:0]  inst;
  logic [31:0]  inst_pc;

  int n_vec  = 0;
  int n_fail = 0;

  ifu_fetch_ctrl #(
    .ADRS_WIDTH (32),
    .LINE_WIDTH (128),
    .INST_WIDTH (32),
    .RESET_PC   (32'h0000_0000)
  ) dut (
    .clock          (clock),
    .rst_n          (rst_n),
    .imem_address   (imem_address),
    .imem_q         (imem_q),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst           (inst),
    .inst_pc        (inst_pc)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Synthetic memory: the word at byte address a holds f(a); line 0 = {4,3,2,1}.
  function automatic logic [31:0] f(input logic [31:0] a);
    return ((a >> 2) + 32'd1) ^ ((a >> 4) << 20);
  endfunction

  function automatic logic [127:0] mem_line(input logic [31:0] line_idx);
    logic [31:0] base;
    base = line_idx << 4;
    return {f(base + 32'd12), f(base + 32'd8), f(base + 32'd4), f(base)};
  endfunction

  always @(posedge clock) imem_q <= mem_line(imem_address);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        rv;
    logic [31:0] rpc;
    logic        rdy;
    logic        ev;
    logic [31:0] einst;
    logic [31:0] epc;
    logic [31:0] eaddr;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic rv, input logic [31:0] rpc, input logic rdy,
                              input logic ev, input logic [31:0] einst,
                              input logic [31:0] epc, input logic [31:0] eaddr);
    vec_t v;
    v.rv = rv; v.rpc = rpc; v.rdy = rdy;
    v.ev = ev; v.einst = einst; v.epc = epc; v.eaddr = eaddr;
    return v;
  endfunction

  // Reference model: pc plus count of bubble cycles before the next valid word.
  logic [31:0] m_pc;
  int          m_wait;

  task automatic step(input logic rv, input logic [31:0] rpc, input logic rdy);
    logic ev;
    redirect_valid = rv;
    redirect_pc    = rpc;
    inst_ready     = rdy;
    @(negedge clock);
    ev = (m_wait == 0) && !rv;
    chk("rand_valid", {31'd0, inst_valid}, {31'd0, ev});
    chk("rand_addr", imem_address, m_pc >> 4);
    if (ev) begin
      chk("rand_inst", inst, f(m_pc));
      chk("rand_pc", inst_pc, m_pc);
    end
    @(posedge clock);
    #1;
    if (rv) begin
      m_pc   = rpc & ~32'h3;
      m_wait = 2;
    end else if (m_wait != 0) begin
      m_wait--;
    end else if (rdy) begin
      m_pc = m_pc + 32'd4;
      if (m_pc[3:0] == 4'h0) m_wait = 2;
    end
  endtask

  initial begin
    rst_n          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    inst_ready     = 1'b1;

    // Directed sequence from reset release; one record per cycle.
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 1, 32'd1, 32'h0, 0));
    for (int i = 0; i < 5; i++) tbl.push_back(mk(0, 0, 0, 1, 32'd2, 32'h4, 0));
    tbl.push_back(mk(0, 0, 1, 1, 32'd2, 32'h4, 0));
    tbl.push_back(mk(0, 0, 1, 1, 32'd3, 32'h8, 0));
    tbl.push_back(mk(0, 0, 1, 1, 32'd4, 32'hC, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 32'h1));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 32'h1));
    tbl.push_back(mk(0, 0, 1, 1, f(32'h10), 32'h10, 32'h1));
    tbl.push_back(mk(1, 32'h126, 1, 0, 0, 0, 32'h1));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 32'h12));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 32'h12));
    tbl.push_back(mk(0, 0, 1, 1, f(32'h124), 32'h124, 32'h12));
    tbl.push_back(mk(1, 32'h50, 1, 0, 0, 0, 32'h12));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 32'h5));
    tbl.push_back(mk(1, 32'h40, 1, 0, 0, 0, 32'h5));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 32'h4));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 32'h4));
    tbl.push_back(mk(0, 0, 1, 1, f(32'h40), 32'h40, 32'h4));
    tbl.push_back(mk(1, 32'hFFFF_FFFC, 1, 0, 0, 0, 32'h4));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 32'h0FFF_FFFF));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 32'h0FFF_FFFF));
    tbl.push_back(mk(0, 0, 1, 1, f(32'hFFFF_FFFC), 32'hFFFF_FFFC, 32'h0FFF_FFFF));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 32'h0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 32'h0));
    tbl.push_back(mk(0, 0, 1, 1, 32'd1, 32'h0, 32'h0));
    tbl.push_back(mk(0, 0, 0, 1, 32'd2, 32'h4, 32'h0));

    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("rst_valid", {31'd0, inst_valid}, 32'd0);
    chk("rst_inst", inst, 32'd0);
    chk("rst_pc", inst_pc, 32'd0);
    chk("rst_addr", imem_address, 32'd0);
    @(posedge clock);
    #1 rst_n = 1'b1;

    foreach (tbl[i]) begin
      redirect_valid = tbl[i].rv;
      redirect_pc    = tbl[i].rpc;
      inst_ready     = tbl[i].rdy;
      @(negedge clock);
      chk($sformatf("tbl%0d_valid", i), {31'd0, inst_valid}, {31'd0, tbl[i].ev});
      chk($sformatf("tbl%0d_addr", i), imem_address, tbl[i].eaddr);
      if (tbl[i].ev) begin
        chk($sformatf("tbl%0d_inst", i), inst, tbl[i].einst);
        chk($sformatf("tbl%0d_pc", i), inst_pc, tbl[i].epc);
      end
      @(posedge clock);
      #1;
    end

    // Async reset between edges while serving pc=4.
    redirect_valid = 1'b0;
    inst_ready     = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("async_valid", {31'd0, inst_valid}, 32'd0);
    chk("async_pc", inst_pc, 32'd0);
    chk("async_addr", imem_address, 32'd0);
    @(posedge clock);
    #1 rst_n = 1'b1;

    m_pc   = 32'h0;
    m_wait = 2;
    inst_ready = 1'b1;
    for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 1'b1);

    for (int i = 0; i < 600; i++) begin
      logic        rv;
      logic [31:0] rpc;
      logic        rdy;
      rv  = ($urandom_range(0, 15) == 0);
      rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFE0 | 32'($urandom_range(0, 31)))
                                        : 32'($urandom_range(0, 1023));
      rdy = ($urandom_range(0, 3) != 0);
      step(rv, rpc, rdy);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
